spmmio_tape_out: RTL and testbench
==================================

# spmmio_tape_out

Cassette-output encoder on the soft-processor MMIO bus. It is the write-side counterpart of the tape `mag_out` decoder. Software pushes bytes into an 8-entry FIFO and can request leader (zero) bits. The block serialises them MSB-first as FM bit cells on `tape_in`, the signal presented to the TI-99 cassette input. It also drives a monitoring square wave on `tape_audio`.

## Interface
Parameters:
- `fifo_depth`, 8: byte FIFO entries. Must be a power of 2, at most 15.
- `default_period`, 2175: reset value of the bit-cell period, in `clk_3mhz_en` ticks (about 1379 bit/s).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `clk_3mhz_en` in 1: tick enable. All encoder timing advances only on ticks.
- `adr` in [0:13]: word address. Registers are selected by `adr[11:13]`.
- `cs` in 1: chip select.
- `sel` in [0:3]: byte lane enables; `sel[0]` covers `d[0:7]`.
- `we` in 1: write strobe.
- `d` in [0:31]: write data.
- `q` out [0:31]: read data. Combinational from `adr[11:13]`; unused bits read 0.
- `cs1_cntrl` in 1: cassette 1 motor. When low, the encoder pauses.
- `tape_in` out 1: FM-encoded cassette level.
- `tape_audio` out [0:15]: monitor audio.

## Operation
Register map, selected by `adr[11:13]`:
- Register 0, CTRL:
  - `d[15]` is `enable` (written via `sel[1]`).
  - `d[20:31]` is `period`: `sel[2]` writes bits 20–23, `sel[3]` writes bits 24–31.
  - Reads return the same fields.
  - The effective period is max(`period`, 4).
- Register 1, DATA/STATUS:
  - A write with `sel[3]` pushes `d[24:31]`.
  - A write with `sel[0]` and `d[1]`=1 clears `underrun`; with `d[2]`=1 it clears `overflow`.
  - Read fields: `q[0]` busy (state≠IDLE), `q[1]` underrun, `q[2]` overflow, `q[3]` FIFO full, `q[4]` FIFO empty, `q[8:11]` FIFO count, `q[16]` `cs1_cntrl`.
- Register 2, LEADER:
  - `d[16:31]` is `leader_cnt`: `sel[2]` writes the high byte, `sel[3]` the low byte.
  - Reads return the remaining `leader_cnt`.

FIFO behaviour:
- A push when full is dropped and sets `overflow`.
- A push and a pop in the same cycle both take effect, so the count is unchanged.
- Writing `enable`=0 flushes the FIFO, clears `leader_cnt`, returns the state machine to IDLE, and forces `tape_in`=0.

State machine IDLE / LEADER / DATA:
- Sub-state: `cell_cnt` (12 bits), `cur_bit`, `shift` (8 bits), `bit_idx` (0–7).
- IDLE → LEADER when `enable` & `cs1_cntrl` & `leader_cnt`≠0. Otherwise IDLE → DATA when the FIFO is non-empty, popping a byte into `shift`. Leader has priority.
- LEADER sends `cur_bit`=0 cells and decrements `leader_cnt` at each cell end.
- DATA sends `shift[7]` first (MSB first), through `bit_idx` 0..7.
- At the end of a leader cell or of bit 7, the next state is chosen as follows:
  1. LEADER if `leader_cnt`≠0 (a write made mid-byte takes effect at the byte boundary);
  2. else DATA with a pop, if the FIFO is non-empty;
  3. else IDLE, with `underrun` set.
- Leaving LEADER for IDLE because `leader_cnt` reached 0 with an empty FIFO also sets `underrun`.

FM encoding, per tick in LEADER/DATA:
- `cell_cnt`==0: toggle `tape_in` (cell boundary).
- `cell_cnt`==P>>1 and `cur_bit`=1: toggle `tape_in` (mid-cell).
- `cell_cnt`==P−1: load the next bit or state and set `cell_cnt`:=0. Otherwise increment `cell_cnt`.
- In IDLE, `tape_in` holds its level and `cell_cnt`=0.

Monitor and pause:
- `tape_audio` = 16'h4000 if `tape_in`, else 16'hC000, while state≠IDLE; 16'h0000 in IDLE.
- `cs1_cntrl` low freezes `cell_cnt`, state, and `tape_in`. `tape_audio` reads 0 during the pause. Operation resumes exactly where it stopped.

## Timing
Reset values:
- `tape_in`=0, `tape_audio`=0, state IDLE, FIFO empty.
- `enable`=0, `period`=`default_period`, `leader_cnt`=0.
- `underrun`=0, `overflow`=0.

Cycle-level rules:
- A FIFO push is visible in status on the next `clk`.
- The IDLE→active transition happens on a tick. That tick counts as `cell_cnt`==0: `tape_in` toggles on it and `cell_cnt`:=1.
- Each cell lasts exactly P ticks.
- For a 1 bit, the mid-cell toggle lands exactly P>>1 ticks after the boundary toggle.
- Back-to-back bytes produce no gap.
- The pop for the next byte occurs on the tick where `cell_cnt`==P−1 of bit 7.
- A `period` write takes effect at the next cell boundary. The current cell completes with the old P.
- Register writes that coincide with a tick take priority over the clears performed by the state machine on that tick, except that `underrun`/`overflow` set-events win over clears.

## Test plan
- **Reset, idle:** after reset, read CTRL → `q[20:31]`=2175, `enable`=0. STATUS → empty=1, count=0. `tape_in`=0, `tape_audio`=0.
- **Single byte:** P=8, `enable`=1, push 8'hA5. Then `tape_in` shows 8 cells of 8 ticks. Cells for 1 bits have toggles at offsets 0 and 4; cells for 0 bits toggle only at 0. After the 8th cell, state is IDLE and `underrun`=1.
- **Leader then data:** P=8, `leader_cnt`=3, push 8'h01. Expect 3 zero cells, then 7 zero cells and one 1-cell, contiguous (24 + 64 ticks). LEADER reads 0 at the end.
- **FIFO full and overflow:** with `cs1_cntrl`=0, push 9 bytes → count=8, full=1, overflow=1, and the 9th byte is discarded. Clearing via `d[2]` → overflow=0.
- **Motor pause:** drop `cs1_cntrl` mid-cell for 50 ticks. `tape_in` and `cell_cnt` are frozen and `tape_audio`=0. On restore, the remaining cell length equals the length left before the pause.
- **Disable mid-byte:** write `enable`=0 during bit 3 with 4 bytes queued. Next cycle: state IDLE, FIFO empty, `tape_in`=0, `leader_cnt`=0, `underrun` unchanged.

Source files
------------

// File: rtl/spmmio_tape_out.sv
// MMIO cassette-output encoder: byte FIFO plus leader counter, serialised
// MSB-first as FM bit cells on tape_in, with a square-wave monitor on tape_audio.
module spmmio_tape_out #(
  parameter int fifo_depth     = 8,
  parameter int default_period = 2175
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_3mhz_en,
  input  logic [0:13] adr,
  input  logic        cs,
  input  logic [0:3]  sel,
  input  logic        we,
  input  logic [0:31] d,
  output logic [0:31] q,
  input  logic        cs1_cntrl,
  output logic        tape_in,
  output logic [0:15] tape_audio
);
  localparam int            PW    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [3:0]    DEPTH = 4'(fifo_depth);
  localparam logic [PW-1:0] LAST  = PW'(fifo_depth - 1);
  localparam logic [11:0]   DEF_P = 12'(default_period);

  typedef enum logic [1:0] {IDLE, LEADER, DATA} state_t;

  function automatic logic [11:0] clamp_period(input logic [11:0] p);
    return (p < 12'd4) ? 12'd4 : p;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic [11:0]   cell_cnt, cell_cnt_nxt, cell_p, cell_p_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          tape_nxt, pop, leader_dec, underrun_set;
  logic [15:0]   leader_left;
  logic          enable, underrun, overflow;
  logic [11:0]   period;
  logic [15:0]   leader_cnt;
  logic [7:0]    fifo_mem [fifo_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;

  logic wr, wr_ctrl, wr_data, wr_lead, push, push_ok, disable_wr;
  logic full, empty, busy, tick, cur_bit;
  logic unused_bits;

  assign wr         = cs & we;
  assign wr_ctrl    = wr && (adr[11:13] == 3'd0);
  assign wr_data    = wr && (adr[11:13] == 3'd1);
  assign wr_lead    = wr && (adr[11:13] == 3'd2);
  assign full       = (count == DEPTH);
  assign empty      = (count == 4'd0);
  assign push       = wr_data & sel[3];
  assign push_ok    = push & ~full;
  assign disable_wr = wr_ctrl & sel[1] & ~d[15];
  assign busy       = (state != IDLE);
  assign tick       = clk_3mhz_en & cs1_cntrl;
  assign cur_bit    = (state == DATA) & shift[7];
  assign unused_bits = ^{adr[0:10], d[0], d[3:14]};

  // Cell sequencer: only ticks with the motor on advance anything
  always_comb begin
    state_nxt    = state;
    cell_cnt_nxt = cell_cnt;
    cell_p_nxt   = cell_p;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    tape_nxt     = tape_in;
    pop          = 1'b0;
    leader_dec   = 1'b0;
    underrun_set = 1'b0;
    leader_left  = leader_cnt;
    if (tick) begin
      if (state == IDLE) begin
        cell_cnt_nxt = 12'd0;
        if (enable && (leader_cnt != 16'd0)) begin
          state_nxt    = LEADER;
          tape_nxt     = ~tape_in;
          cell_cnt_nxt = 12'd1;
          cell_p_nxt   = clamp_period(period);
        end else if (enable && !empty) begin
          state_nxt    = DATA;
          pop          = 1'b1;
          shift_nxt    = fifo_mem[rd_ptr];
          bit_idx_nxt  = 3'd0;
          tape_nxt     = ~tape_in;
          cell_cnt_nxt = 12'd1;
          cell_p_nxt   = clamp_period(period);
        end
      end else begin
        if (cell_cnt == 12'd0)
          tape_nxt = ~tape_in;
        else if (cur_bit && (cell_cnt == {1'b0, cell_p[11:1]}))
          tape_nxt = ~tape_in;
        if (cell_cnt == cell_p - 12'd1) begin
          cell_cnt_nxt = 12'd0;
          cell_p_nxt   = clamp_period(period);
          if ((state == DATA) && (bit_idx != 3'd7)) begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {shift[6:0], 1'b0};
          end else begin
            leader_dec  = (state == LEADER);
            leader_left = (state == LEADER) ? leader_cnt - 16'd1 : leader_cnt;
            if (leader_left != 16'd0) begin
              state_nxt = LEADER;
            end else if (!empty) begin
              state_nxt   = DATA;
              pop         = 1'b1;
              shift_nxt   = fifo_mem[rd_ptr];
              bit_idx_nxt = 3'd0;
            end else begin
              state_nxt    = IDLE;
              underrun_set = 1'b1;
            end
          end
        end else begin
          cell_cnt_nxt = cell_cnt + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= d[24:31];
    shift <= shift_nxt;
  end

  // Control state; bus writes land after the sequencer so they win on collisions
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cell_cnt   <= 12'd0;
      cell_p     <= clamp_period(DEF_P);
      bit_idx    <= 3'd0;
      tape_in    <= 1'b0;
      enable     <= 1'b0;
      period     <= DEF_P;
      leader_cnt <= 16'd0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 4'd0;
    end else begin
      state    <= state_nxt;
      cell_cnt <= cell_cnt_nxt;
      cell_p   <= cell_p_nxt;
      bit_idx  <= bit_idx_nxt;
      tape_in  <= tape_nxt;
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {3'd0, push_ok} - {3'd0, pop};
      if (leader_dec) leader_cnt <= leader_cnt - 16'd1;
      if (wr_data && sel[0] && d[1]) underrun <= 1'b0;
      if (wr_data && sel[0] && d[2]) overflow <= 1'b0;
      if (underrun_set)  underrun <= 1'b1;
      if (push && full)  overflow <= 1'b1;
      if (wr_ctrl) begin
        if (sel[1]) enable       <= d[15];
        if (sel[2]) period[11:8] <= d[20:23];
        if (sel[3]) period[7:0]  <= d[24:31];
      end
      if (wr_lead) begin
        if (sel[2]) leader_cnt[15:8] <= d[16:23];
        if (sel[3]) leader_cnt[7:0]  <= d[24:31];
      end
      if (disable_wr) begin
        state      <= IDLE;
        cell_cnt   <= 12'd0;
        bit_idx    <= 3'd0;
        tape_in    <= 1'b0;
        leader_cnt <= 16'd0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= 4'd0;
      end
    end
  end

  always_comb begin
    q = '0;
    case (adr[11:13])
      3'd0: begin
        q[15]    = enable;
        q[20:31] = period;
      end
      3'd1: begin
        q[0]    = busy;
        q[1]    = underrun;
        q[2]    = overflow;
        q[3]    = full;
        q[4]    = empty;
        q[8:11] = count;
        q[16]   = cs1_cntrl;
      end
      3'd2:    q[16:31] = leader_cnt;
      default: q = '0;
    endcase
  end

  assign tape_audio = (busy && cs1_cntrl) ? (tape_in ? 16'h4000 : 16'hC000) : 16'h0000;
endmodule

// File: tb/tb_spmmio_tape_out.sv
// Bench for spmmio_tape_out: a cell-gap scoreboard fed as bytes/leader are
// written, drained by a tape_in edge monitor counting clk_3mhz_en ticks.
module tb_spmmio_tape_out;
  logic        clk = 1'b0, reset = 1'b1, clk_3mhz_en = 1'b0;
  logic        cs = 1'b0, we = 1'b0, cs1_cntrl = 1'b1;
  logic [0:13] adr = '0;
  logic [0:3]  sel = '0;
  logic [0:31] d = '0;
  logic [0:31] q;
  logic        tape_in;
  logic [0:15] tape_audio;

  int   n_checks = 0, n_err = 0;
  int   sb[$];
  bit   mon_en = 1'b1, have_prev = 1'b0, sess_started = 1'b0;
  int   model_gap = 0, model_cnt = 0, P = 8;
  logic [0:31] rd;
  logic        frozen;

  spmmio_tape_out #(.fifo_depth(8), .default_period(2175)) dut (
    .clk(clk), .reset(reset), .clk_3mhz_en(clk_3mhz_en), .adr(adr), .cs(cs),
    .sel(sel), .we(we), .d(d), .q(q), .cs1_cntrl(cs1_cntrl),
    .tape_in(tape_in), .tape_audio(tape_audio)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 clk_3mhz_en = ~clk_3mhz_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: gap (ticks) from each expected toggle to the previous one
  task automatic add_cell(input bit b);
    if (!sess_started) sess_started = 1'b1;
    else sb.push_back(model_gap);
    if (b) begin
      sb.push_back(P / 2);
      model_gap = P - P / 2;
    end else begin
      model_gap = P;
    end
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) add_cell(v[i]);
  endtask

  task automatic bus_write(input logic [2:0] r, input logic [0:3] s, input logic [31:0] v);
    @(posedge clk);
    #1;
    adr = {11'd0, r}; cs = 1'b1; we = 1'b1; sel = s; d = v;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic rd_reg(input logic [2:0] r);
    @(posedge clk);
    #1;
    adr = {11'd0, r}; cs = 1'b1; we = 1'b0;
    #2;
    rd = q;
    cs = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    bus_write(3'd1, 4'b0001, {24'd0, v});
    if (model_cnt < 8) begin
      model_cnt++;
      add_byte(v);
    end
  endtask

  task automatic start_session();
    sb.delete();
    have_prev = 1'b0;
    sess_started = 1'b0;
    model_cnt = 0;
  endtask

  task automatic wait_idle(input int budget);
    repeat (6) @(posedge clk);
    for (int i = 0; i < budget; i++) begin
      rd_reg(3'd1);
      if (!rd[0]) break;
    end
    chk("idle_wait_busy", rd[0], 0);
  endtask

  // Edge monitor: counts motor-on ticks between tape_in transitions
  initial begin
    logic prev_tape;
    int   ticks, exp;
    prev_tape = 1'b0;
    ticks = 0;
    forever begin
      @(negedge clk);
      if (tape_in !== prev_tape) begin
        prev_tape = tape_in;
        if (mon_en) begin
          if (have_prev) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 0;
            chk("cell_gap", ticks, exp);
          end
          have_prev = 1'b1;
        end
        ticks = 0;
      end
      if (clk_3mhz_en && cs1_cntrl) ticks++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes9 [9];
    bytes9 = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3, 8'h12, 8'hE7, 8'h99};
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_tape_in", tape_in, 0);
    chk("rst_audio", tape_audio, 0);
    rd_reg(3'd0);
    chk("rst_period", rd[20:31], 2175);
    chk("rst_enable", rd[15], 0);
    rd_reg(3'd1);
    chk("rst_empty", rd[4], 1);
    chk("rst_count", rd[8:11], 0);
    chk("rst_underrun", rd[1], 0);
    chk("rst_overflow", rd[2], 0);
    rd_reg(3'd2);
    chk("rst_leader", rd[16:31], 0);

    // Single byte A5 at P=8
    P = 8;
    bus_write(3'd0, 4'b0111, 32'h0001_0008);
    rd_reg(3'd0);
    chk("ctrl_period", rd[20:31], 8);
    chk("ctrl_enable", rd[15], 1);
    start_session();
    push_byte(8'hA5);
    wait_idle(600);
    chk("a5_sb_left", sb.size(), 0);
    rd_reg(3'd1);
    chk("a5_underrun", rd[1], 1);
    bus_write(3'd1, 4'b1000, 32'h4000_0000);
    rd_reg(3'd1);
    chk("underrun_clr", rd[1], 0);

    // Three leader cells then byte 01
    start_session();
    bus_write(3'd2, 4'b0011, 32'h0000_0003);
    for (int i = 0; i < 3; i++) add_cell(1'b0);
    push_byte(8'h01);
    wait_idle(800);
    chk("lead_sb_left", sb.size(), 0);
    rd_reg(3'd2);
    chk("lead_end_cnt", rd[16:31], 0);
    rd_reg(3'd1);
    chk("lead_underrun", rd[1], 1);
    bus_write(3'd1, 4'b1000, 32'h4000_0000);

    // Overflow with motor off, then play the 8 kept bytes with a pause
    @(posedge clk);
    #1 cs1_cntrl = 1'b0;
    start_session();
    for (int i = 0; i < 9; i++) push_byte(bytes9[i]);
    rd_reg(3'd1);
    chk("ovf_count", rd[8:11], 8);
    chk("ovf_full", rd[3], 1);
    chk("ovf_flag", rd[2], 1);
    chk("ovf_empty", rd[4], 0);
    chk("ovf_motor_bit", rd[16], 0);
    bus_write(3'd1, 4'b1000, 32'h2000_0000);
    rd_reg(3'd1);
    chk("ovf_clr", rd[2], 0);
    chk("ovf_count_kept", rd[8:11], 8);
    @(posedge clk);
    #1 cs1_cntrl = 1'b1;
    repeat (45) @(posedge clk);
    #2;
    chk("audio_active", tape_audio, tape_in ? 16'h4000 : 16'hC000);
    cs1_cntrl = 1'b0;
    frozen = tape_in;
    repeat (100) @(posedge clk);
    #2;
    chk("pause_tape_frozen", tape_in, frozen);
    chk("pause_audio", tape_audio, 0);
    rd_reg(3'd1);
    chk("pause_busy", rd[0], 1);
    @(posedge clk);
    #1 cs1_cntrl = 1'b1;
    wait_idle(3000);
    chk("stream_sb_left", sb.size(), 0);
    rd_reg(3'd1);
    chk("stream_underrun", rd[1], 1);
    bus_write(3'd1, 4'b1000, 32'h4000_0000);

    // Disable mid-byte with bytes queued and a pending leader request
    mon_en = 1'b0;
    start_session();
    bus_write(3'd1, 4'b0001, 32'h0000_00F0);
    bus_write(3'd1, 4'b0001, 32'h0000_000F);
    bus_write(3'd1, 4'b0001, 32'h0000_0055);
    bus_write(3'd1, 4'b0001, 32'h0000_00AA);
    repeat (36) @(posedge clk);
    bus_write(3'd2, 4'b0011, 32'h0000_0005);
    rd_reg(3'd2);
    chk("dis_leader_pre", rd[16:31], 5);
    rd_reg(3'd1);
    chk("dis_busy_pre", rd[0], 1);
    bus_write(3'd0, 4'b0100, 32'h0000_0000);
    rd_reg(3'd1);
    chk("dis_busy", rd[0], 0);
    chk("dis_empty", rd[4], 1);
    chk("dis_count", rd[8:11], 0);
    chk("dis_underrun", rd[1], 0);
    chk("dis_tape_in", tape_in, 0);
    chk("dis_audio", tape_audio, 0);
    rd_reg(3'd2);
    chk("dis_leader", rd[16:31], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
